intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_if.sv | 14 +
 rtl/intr_ctrl.sv | 119 +++++++++++
 tb/tb_intr_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intr_ctrl_if.sv
// CPU-side bus and interrupt handshake for intr_ctrl.
// The CPU holds the master end and the controller holds the slave end.
interface intr_ctrl_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] abus;
    logic             we;
    logic             intr;
    logic             intr_ack;
    logic [3:0]       intr_id;

    modport master (output abus, we, intr_ack, input intr, intr_id);
    modport slave  (input abus, we, intr_ack, output intr, intr_id);
endinterface

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: edge-captured pending bits, an enable mask,
// and a single IDLE/REQ/SVC service channel. Bit 0 has the highest priority.
module intr_ctrl #(
    parameter int               DBITS     = 32,
    parameter int               NSRC      = 4,
    parameter logic [DBITS-1:0] PEND_ADDR = 32'hF0000800,
    parameter logic [DBITS-1:0] MASK_ADDR = 32'hF0000804,
    parameter logic [DBITS-1:0] STAT_ADDR = 32'hF0000808
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic [NSRC-1:0]  irq,
    inout  wire  [DBITS-1:0] dbus,
    intr_ctrl_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       id_q, id_d;
    logic [NSRC-1:0]  irq_q, irq_prev_q;
    logic [NSRC-1:0]  pend_q, pend_d;
    logic [NSRC-1:0]  mask_q, mask_d;
    logic [NSRC-1:0]  active, rise, id_oh, w1c, ack_clr;
    logic [3:0]       first_id;
    logic             wr_pend, wr_mask, wr_stat;
    logic             rd_en;
    logic [DBITS-1:0] rd_data;

    assign wr_pend = bus.we && (bus.abus == PEND_ADDR);
    assign wr_mask = bus.we && (bus.abus == MASK_ADDR);
    assign wr_stat = bus.we && (bus.abus == STAT_ADDR);

    // irq is first captured into irq_q; the edge is taken between two captured
    // samples so the path is capture -> pend -> REQ.
    assign rise    = irq_q & ~irq_prev_q;
    assign active  = pend_q & mask_q;
    assign id_oh   = NSRC'(1) << id_q;
    assign w1c     = wr_pend ? dbus[NSRC-1:0] : '0;
    assign ack_clr = (state_q == REQ && bus.intr_ack) ? id_oh : '0;

    // A new edge wins over a same-cycle clear so no arrival is ever lost.
    assign pend_d  = (pend_q & ~(w1c | ack_clr)) | rise;
    assign mask_d  = wr_mask ? dbus[NSRC-1:0] : mask_q;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        first_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) first_id = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = REQ;
                    id_d    = first_id;
                end
            end
            REQ: begin
                if (bus.intr_ack)              state_d = SVC;
                else if (!(|(active & id_oh))) state_d = IDLE;
            end
            SVC: begin
                if (wr_stat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q    <= IDLE;
            id_q       <= '0;
            irq_q      <= '0;
            irq_prev_q <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            irq_q      <= irq;
            irq_prev_q <= irq_q;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
        end
    end

    assign bus.intr    = (state_q == REQ);
    assign bus.intr_id = id_q;

    always_comb begin
        rd_en   = 1'b0;
        rd_data = '0;
        if (init_n && !bus.we) begin
            if (bus.abus == PEND_ADDR) begin
                rd_en              = 1'b1;
                rd_data[NSRC-1:0]  = pend_q;
            end else if (bus.abus == MASK_ADDR) begin
                rd_en              = 1'b1;
                rd_data[NSRC-1:0]  = mask_q;
            end else if (bus.abus == STAT_ADDR) begin
                rd_en              = 1'b1;
                rd_data[9:8]       = state_q;
                rd_data[3:0]       = id_q;
            end
        end
    end

    assign dbus = rd_en ? rd_data : {DBITS{1'bz}};
endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios followed by random bus
// and irq traffic, all compared against a behavioural model of the controller.
module tb_intr_ctrl;
    localparam int          DBITS  = 32;
    localparam int          NSRC   = 4;
    localparam logic [31:0] PEND_A = 32'hF0000800;
    localparam logic [31:0] MASK_A = 32'hF0000804;
    localparam logic [31:0] STAT_A = 32'hF0000808;
    localparam logic [31:0] NONE_A = 32'h0000_0000;

    logic             clk    = 1'b0;
    logic             init_n = 1'b0;
    logic [NSRC-1:0]  irq    = '0;
    logic [DBITS-1:0] wdata  = '0;
    logic [31:0]      rd_val;
    wire  [DBITS-1:0] dbus;

    int n_tests = 0;
    int n_fail  = 0;

    intr_ctrl_if #(.DBITS(DBITS)) bus ();

    assign dbus = bus.we ? wdata : {DBITS{1'bz}};

    intr_ctrl #(
        .DBITS(DBITS), .NSRC(NSRC),
        .PEND_ADDR(PEND_A), .MASK_ADDR(MASK_A), .STAT_ADDR(STAT_A)
    ) dut (
        .clk   (clk),
        .init_n(init_n),
        .irq   (irq),
        .dbus  (dbus),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: per-source pending/enable flags, the last two irq
    // samples, and the service phase (0 idle, 1 requesting, 2 in service).
    bit m_pend[NSRC];
    bit m_mask[NSRC];
    bit m_cap[NSRC];
    bit m_cap_old[NSRC];
    int m_phase;
    int m_owner;

    function void model_reset();
        for (int s = 0; s < NSRC; s++) begin
            m_pend[s] = 0; m_mask[s] = 0; m_cap[s] = 0; m_cap_old[s] = 0;
        end
        m_phase = 0;
        m_owner = 0;
    endfunction

    function automatic logic [31:0] pend_word();
        logic [31:0] w;
        w = '0;
        for (int s = 0; s < NSRC; s++) w[s] = m_pend[s];
        return w;
    endfunction

    function automatic logic [31:0] mask_word();
        logic [31:0] w;
        w = '0;
        for (int s = 0; s < NSRC; s++) w[s] = m_mask[s];
        return w;
    endfunction

    function automatic logic [31:0] stat_word();
        return 32'(m_phase * 256 + m_owner);
    endfunction

    function void model_step(input logic [31:0] addr, input bit wr,
                             input logic [31:0] data, input bit ack);
        bit nxt_pend[NSRC];
        int wanted;
        bit owner_live;
        wanted = -1;
        for (int s = NSRC - 1; s >= 0; s--)
            if (m_pend[s] && m_mask[s]) wanted = s;
        owner_live = m_pend[m_owner] && m_mask[m_owner];
        for (int s = 0; s < NSRC; s++) begin
            nxt_pend[s] = m_pend[s];
            if (wr && addr == PEND_A && data[s]) nxt_pend[s] = 0;
            if (m_phase == 1 && ack && s == m_owner) nxt_pend[s] = 0;
            if (m_cap[s] && !m_cap_old[s]) nxt_pend[s] = 1;
        end
        if (m_phase == 0) begin
            if (wanted >= 0) begin
                m_phase = 1;
                m_owner = wanted;
            end
        end else if (m_phase == 1) begin
            if (ack) m_phase = 2;
            else if (!owner_live) m_phase = 0;
        end else begin
            if (wr && addr == STAT_A) m_phase = 0;
        end
        for (int s = 0; s < NSRC; s++) begin
            if (wr && addr == MASK_A) m_mask[s] = data[s];
            m_pend[s]    = nxt_pend[s];
            m_cap_old[s] = m_cap[s];
            m_cap[s]     = irq[s];
        end
    endfunction

    // One bus cycle: drive, compare at the falling edge, advance the model,
    // then step past the rising edge.
    task automatic cycle(input logic [31:0] addr, input bit wr,
                         input logic [31:0] data, input bit ack);
        bus.abus     = addr;
        bus.we       = wr;
        wdata        = data;
        bus.intr_ack = ack;
        @(negedge clk);
        check("intr", {31'd0, bus.intr}, {31'd0, m_phase == 1});
        check("intr_id", {28'd0, bus.intr_id}, 32'(m_owner));
        rd_val = dbus;
        if (!wr && addr == PEND_A) check("rd_pend", rd_val, pend_word());
        if (!wr && addr == MASK_A) check("rd_mask", rd_val, mask_word());
        if (!wr && addr == STAT_A) check("rd_stat", rd_val, stat_word());
        model_step(addr, wr, data, ack);
        @(posedge clk);
        #1;
        bus.abus     = NONE_A;
        bus.we       = 1'b0;
        bus.intr_ack = 1'b0;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cycle(NONE_A, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        cycle(addr, 1'b1, data, 1'b0);
    endtask

    task automatic rd(input logic [31:0] addr);
        cycle(addr, 1'b0, '0, 1'b0);
    endtask

    task automatic ack_cyc();
        cycle(NONE_A, 1'b0, '0, 1'b1);
    endtask

    task automatic pulse_reset();
        init_n = 1'b0;
        #2;
        check("rst_intr", {31'd0, bus.intr}, 32'd0);
        check("rst_id", {28'd0, bus.intr_id}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        init_n = 1'b1;
    endtask

    initial begin
        int r;
        bus.abus     = NONE_A;
        bus.we       = 1'b0;
        bus.intr_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset();
        rd(PEND_A); check("reset_pend", rd_val, 32'h0);
        rd(MASK_A); check("reset_mask", rd_val, 32'h0);
        rd(STAT_A); check("reset_stat", rd_val, 32'h0);

        // Single source: three-cycle latency, ack, EOI.
        wr(MASK_A, 32'hF);
        irq = 4'b0100;
        nop(1); check("lat_c1", {31'd0, bus.intr}, 32'd0);
        nop(1); check("lat_c2", {31'd0, bus.intr}, 32'd0);
        nop(1); check("lat_c3", {31'd0, bus.intr}, 32'd1);
        check("lat_id", {28'd0, bus.intr_id}, 32'd2);
        ack_cyc();
        rd(PEND_A); check("ack_pend", rd_val, 32'h0);
        rd(STAT_A); check("svc_stat", rd_val, 32'h202);
        wr(STAT_A, 32'h1234);
        rd(STAT_A); check("eoi_stat", rd_val, 32'h002);
        irq = '0;
        nop(3);

        // Simultaneous arrivals: lower index first, the other follows EOI.
        irq = 4'b1010;
        nop(3);
        check("prio_id", {28'd0, bus.intr_id}, 32'd1);
        ack_cyc();
        wr(STAT_A, 32'h0);
        nop(1);
        check("next_intr", {31'd0, bus.intr}, 32'd1);
        check("next_id", {28'd0, bus.intr_id}, 32'd3);
        ack_cyc();
        wr(STAT_A, 32'h0);
        irq = '0;
        nop(2);

        // Masked source stays pending, then is raised once enabled.
        wr(MASK_A, 32'h0);
        irq = 4'b0001;
        nop(3);
        rd(PEND_A); check("masked_pend", rd_val, 32'h1);
        check("masked_intr", {31'd0, bus.intr}, 32'd0);
        wr(MASK_A, 32'h1);
        check("unmask_c1", {31'd0, bus.intr}, 32'd0);
        nop(1);
        check("unmask_c2", {31'd0, bus.intr}, 32'd1);

        // Pending cleared by software while requesting: withdraw without ack.
        wr(PEND_A, 32'h1);
        nop(1);
        check("w1c_intr", {31'd0, bus.intr}, 32'd0);
        rd(STAT_A); check("w1c_stat", rd_val, 32'h000);
        irq = '0;
        nop(2);

        // Reset in service abandons everything at once.
        wr(MASK_A, 32'hF);
        irq = 4'b0100;
        nop(3);
        ack_cyc();
        rd(STAT_A); check("pre_rst_stat", rd_val, 32'h202);
        pulse_reset();
        rd(PEND_A); check("post_rst_pend", rd_val, 32'h0);
        check("post_rst_intr1", {31'd0, bus.intr}, 32'd0);
        rd(STAT_A); check("post_rst_stat", rd_val, 32'h0);
        check("post_rst_intr2", {31'd0, bus.intr}, 32'd0);
        irq = '0;
        nop(3);

        // Clear coincident with a new edge on the same bit keeps it pending.
        wr(PEND_A, 32'hF);
        nop(2);
        irq = 4'b0100;
        nop(1);
        wr(PEND_A, 32'h4);
        rd(PEND_A); check("set_wins", rd_val, 32'h4);
        wr(PEND_A, 32'h4);
        rd(PEND_A); check("plain_w1c", rd_val, 32'h0);
        irq = '0;
        nop(2);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a, d;
            bit w, k;
            if (c == 1500) pulse_reset();
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, NSRC - 1);
                irq[r] = ~irq[r];
            end
            r = $urandom_range(0, 99);
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            w = 1'b0;
            if      (r < 30) a = NONE_A;
            else if (r < 45) a = PEND_A;
            else if (r < 55) a = MASK_A;
            else if (r < 65) a = STAT_A;
            else if (r < 70) a = 32'hF000080C;
            else begin
                w = 1'b1;
                if      (r < 80) a = PEND_A;
                else if (r < 88) a = MASK_A;
                else if (r < 93) a = STAT_A;
                else             a = 32'hF0000810;
            end
            k = bus.intr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            cycle(a, w, d, k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
